// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding, oversample ratio and tick-counter width helper shared by UART TX and RX
package uart_pkg;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam int OVERSAMPLE = 16;
    function automatic int tick_w(input int sb_tick);
        return (sb_tick > OVERSAMPLE) ? 6 : 4;
    endfunction
endpackage

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: sends one UART frame per accepted request, paced by the shared 16x tick
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_tx_done
);
    localparam int SW = tick_w(SB_TICK);
    localparam int NW = $clog2(NB_DATA);
    logic [2:0]         state;
    logic [SW-1:0]      s;
    logic [NW-1:0]      n;
    logic [NB_DATA-1:0] shift;
    logic [NB_DATA-1:0] data_q;
    logic               bit_end;
    logic               parity_bit;
    assign bit_end    = i_tick && (s == SW'(OVERSAMPLE - 1));
    assign parity_bit = ^data_q ^ 1'(PARITY_ODD);
    // frame FSM; o_tx is set together with the state it belongs to so the pin stays registered
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            shift     <= '0;
            data_q    <= '0;
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_tx_start) begin
                        state  <= START;
                        shift  <= i_data;
                        data_q <= i_data;
                        s      <= '0;
                        n      <= '0;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        s     <= '0;
                        state <= DATA;
                        o_tx  <= shift[0];
                    end else if (i_tick) begin
                        s <= s + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        s     <= '0;
                        shift <= shift >> 1;
                        if (n == NW'(NB_DATA - 1)) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                            o_tx  <= (PARITY_EN != 0) ? parity_bit : 1'b1;
                        end else begin
                            n    <= n + 1'b1;
                            o_tx <= shift[1];
                        end
                    end else if (i_tick) begin
                        s <= s + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        s     <= '0;
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end else if (i_tick) begin
                        s <= s + 1'b1;
                    end
                end
                STOP: begin
                    if (i_tick && (s == SW'(SB_TICK - 1))) begin
                        s         <= '0;
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_tx_done <= 1'b1;
                    end else if (i_tick) begin
                        s <= s + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: scoreboard bench decoding frames from four parameter variants
module tb_uart_tx_sequencer;
    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          ticks;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] start;
    logic [7:0] din [4];
    wire  [3:0] tx;
    wire  [3:0] busy;
    wire  [3:0] done;
    int         vectors = 0;
    int         miscompares = 0;
    bit         tick_en = 1'b1;
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       q3[$];

    always #5 clk = ~clk;

    uart_tx_sequencer u0 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[0]), .i_data(din[0]),
        .o_tx(tx[0]), .o_busy(busy[0]), .o_tx_done(done[0]));
    uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[1]), .i_data(din[1]),
        .o_tx(tx[1]), .o_busy(busy[1]), .o_tx_done(done[1]));
    uart_tx_sequencer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[2]), .i_data(din[2]),
        .o_tx(tx[2]), .o_busy(busy[2]), .o_tx_done(done[2]));
    uart_tx_sequencer #(.SB_TICK(32)) u3 (
        .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_tx_start(start[3]), .i_data(din[3]),
        .o_tx(tx[3]), .o_busy(busy[3]), .o_tx_done(done[3]));

    // one tick every 4 clocks unless stalled
    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div  = (div + 1) % 4;
            tick = tick_en && (div == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [15:0] b, input int nb, input int t);
        exp_t e;
        e.bits = b;
        e.nb = nb;
        e.ticks = t;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic pop(input int id, output exp_t e, output bit ok);
        ok = 1'b1;
        e.bits = '0;
        e.nb = 0;
        e.ticks = 0;
        case (id)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            2: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
            default: if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // decode the line mid-bit and count ticks consumed while busy; compare at each done pulse
    task automatic mon(input int id);
        bit          active;
        int          cnt;
        int          nb;
        logic [15:0] got;
        exp_t        e;
        bit          ok;
        active = 1'b0;
        cnt = 0;
        nb = 0;
        got = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (done[id]) begin
                pop(id, e, ok);
                vectors++;
                if (!ok) begin
                    miscompares++;
                    $display("FAIL frame%0d: done with no frame expected", id);
                end else if (got !== e.bits || nb != e.nb || cnt != e.ticks) begin
                    miscompares++;
                    $display("FAIL frame%0d: got bits=%h n=%0d ticks=%0d, expected bits=%h n=%0d ticks=%0d",
                             id, got, nb, cnt, e.bits, e.nb, e.ticks);
                end
                active = 1'b0;
            end else if (busy[id]) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    nb = 0;
                    got = '0;
                end
                if (tick) begin
                    if (cnt % 16 == 8 && nb < 16) begin
                        got[nb] = tx[id];
                        nb++;
                    end
                    cnt++;
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    task automatic wait_idle(input int maxcyc);
        for (int i = 0; i < maxcyc; i++) begin
            @(posedge clk);
            #1;
            if (busy == 4'h0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_idle: busy=%b still set after %0d clk", busy, maxcyc);
    endtask

    initial begin
        bit   found;
        bit   changed;
        logic v;
        rst   = 1'b1;
        start = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_hold", {20'h0, tx, busy, done}, {20'h0, 4'hF, 4'h0, 4'h0});
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        din[0] = 8'hA5;
        din[1] = 8'h07;
        din[2] = 8'h07;
        din[3] = 8'hA5;
        push(0, 16'h034A, 10, 160);
        push(1, 16'h060E, 11, 176);
        push(2, 16'h040E, 11, 176);
        push(3, 16'h074A, 11, 176);
        start = 4'hF;
        @(posedge clk);
        #1;
        start = 4'h0;
        chk("accept_latency", {30'h0, tx[0], busy[0]}, 32'h1);
        repeat (200) @(posedge clk);
        #1;
        start[0] = 1'b1;
        din[0]   = 8'h3C;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("busy_ignore", {31'h0, busy[0]}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (done[0]) found = 1'b1;
        end
        chk("done_seen", {31'h0, found}, 32'h1);
        din[0]   = 8'h81;
        start[0] = 1'b1;
        push(0, 16'h0302, 10, 160);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("back_to_back", {29'h0, tx[0], busy[0], done[0]}, 32'h2);
        repeat (100) @(posedge clk);
        #1;
        tick_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        v = tx[0];
        changed = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (tx[0] !== v || busy[0] !== 1'b1) changed = 1'b1;
        end
        chk("stall_hold", {31'h0, changed}, 32'h0);
        tick_en = 1'b1;
        wait_idle(3000);
        din[0]   = 8'hF0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (290) @(posedge clk);
        #1;
        chk("pre_reset_bit4", {30'h0, tx[0], busy[0]}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_reset", {29'h0, tx[0], busy[0], done[0]}, 32'h4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done[0] || busy[0]) found = 1'b1;
        end
        chk("no_done_after_reset", {31'h0, found}, 32'h0);
        din[0]   = 8'h55;
        start[0] = 1'b1;
        push(0, 16'h02AA, 10, 160);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        wait_idle(3000);
        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", q0.size() + q1.size() + q2.size() + q3.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
